byte_serializer: RTL



---
 rtl/byte_serializer_if.sv | 24 ++
 rtl/byte_serializer.sv | 104 ++++++++++
 2 files changed

// File: rtl/byte_serializer_if.sv
// Byte-in / bit-out handshake bundle for byte_serializer.
// slave = serializer side, master = upstream source plus downstream sink.
interface byte_serializer_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] D;
   logic             VALID;
   logic             READY;
   logic             SDO;
   logic             SVALID;
   logic             SREADY;
   logic             LAST;
   logic             BUSY;

   modport slave (
      input  D, VALID, SREADY,
      output READY, SDO, SVALID, LAST, BUSY
   );

   modport master (
      output D, VALID, SREADY,
      input  READY, SDO, SVALID, LAST, BUSY
   );
endinterface

// File: rtl/byte_serializer.sv
// Parallel-to-serial shifter with per-bit back-pressure and optional
// even-parity trailer; all outputs come straight from registers.
module byte_serializer #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1,
   parameter int PARITY_EN = 0
) (
   input  logic            CLK,
   input  logic            RST_N,
   byte_serializer_if.slave bus
);
   localparam int N  = WIDTH + PARITY_EN;
   localparam int CW = $clog2(N + 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t         state, state_n;
   logic [N-1:0]   sreg, sreg_n;
   logic [CW-1:0]  cnt, cnt_n;
   logic           ready, ready_n;
   logic           svalid, svalid_n;
   logic           last, last_n;
   logic           busy, busy_n;
   logic           sdo;
   logic           take;
   logic           load;

   // Frame is stored in send order: bit N-1 goes out first.
   function automatic logic [N-1:0] frame(input logic [WIDTH-1:0] d);
      logic [N-1:0] f;
      f = '0;
      for (int i = 0; i < WIDTH; i++) begin
         f[N-WIDTH+i] = (MSB_FIRST != 0) ? d[i] : d[WIDTH-1-i];
      end
      if (PARITY_EN != 0) f[0] = ^d;
      return f;
   endfunction

   assign take = svalid & bus.SREADY;
   assign load = ready & bus.VALID &
                 ((state == IDLE) | (take & last));

   always_comb begin
      state_n  = state;
      sreg_n   = sreg;
      cnt_n    = cnt;
      ready_n  = ready;
      svalid_n = svalid;
      last_n   = last;
      busy_n   = busy;
      if (load) begin
         state_n  = SHIFT;
         sreg_n   = frame(bus.D);
         cnt_n    = '0;
         svalid_n = 1'b1;
         busy_n   = 1'b1;
         ready_n  = (N == 1);
         last_n   = (N == 1);
      end else if (state == IDLE) begin
         ready_n = 1'b1;
      end else if (take && last) begin
         state_n  = IDLE;
         sreg_n   = '0;
         cnt_n    = '0;
         svalid_n = 1'b0;
         busy_n   = 1'b0;
         ready_n  = 1'b1;
         last_n   = 1'b0;
      end else if (take) begin
         sreg_n  = sreg << 1;
         cnt_n   = cnt + 1'b1;
         last_n  = (cnt_n == CW'(N - 1));
         ready_n = last_n;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state  <= IDLE;
         sreg   <= '0;
         cnt    <= '0;
         ready  <= 1'b0;
         svalid <= 1'b0;
         last   <= 1'b0;
         busy   <= 1'b0;
         sdo    <= 1'b0;
      end else begin
         state  <= state_n;
         sreg   <= sreg_n;
         cnt    <= cnt_n;
         ready  <= ready_n;
         svalid <= svalid_n;
         last   <= last_n;
         busy   <= busy_n;
         sdo    <= sreg_n[N-1];
      end
   end

   assign bus.READY  = ready;
   assign bus.SVALID = svalid;
   assign bus.LAST   = last;
   assign bus.BUSY   = busy;
   assign bus.SDO    = sdo;
endmodule
